branch_redirect_ctrl: RTL and testbench
=======================================

# branch_redirect_ctrl

Sequences the fetch redirect that follows a taken branch, JAL or JALR resolved in EX. It consumes the branch decision and computed target, kills wrong-path instructions in IF/ID, and holds fetch while wrong-path instruction-memory responses drain. It then issues a single redirect pulse to the PC register. It sits between the EX-stage branch decision logic and the fetch unit / imem port.

## Interface
- XLEN, 32, address width
- MAX_OUTSTANDING, 2, maximum in-flight imem fetch requests (≥1)

- clk_i  in  1  clock
- rst_ni  in  1  synchronous reset, active-low
- ex_valid_i  in  1  EX holds a valid instruction this cycle
- take_branch_i  in  1  branch/jump taken decision for EX instruction
- target_i  in  XLEN  computed branch/jump target
- imem_req_accept_i  in  1  fetch request accepted by imem this cycle
- imem_rsp_valid_i  in  1  imem response returned this cycle
- flush_if_o  out  1  invalidate IF stage contents
- flush_id_o  out  1  invalidate ID stage contents
- fetch_hold_o  out  1  fetch must not issue new requests
- drop_rsp_o  out  1  current imem response is wrong-path; discard
- redirect_valid_o  out  1  one-cycle pulse: load PC with redirect_pc_o
- redirect_pc_o  out  XLEN  redirect target
- exc_misaligned_o  out  1  one-cycle pulse: target not 4-byte aligned
- busy_o  out  1  state != IDLE

## Operation
- Trigger = ex_valid_i & take_branch_i & (state == IDLE). Triggers in any other state are ignored.
- Outstanding counter cnt, width $clog2(MAX_OUTSTANDING+1):
  - +1 on accept, −1 on rsp; both in the same cycle leave it unchanged.
  - rsp at cnt==0 is ignored; cnt stays 0.
  - Accept at cnt==MAX_OUTSTANDING is ignored; cnt saturates.
- cnt_next = cnt after this cycle's accept/rsp update.
- States: IDLE, DRAIN, REDIRECT, EXC.
- IDLE:
  - On trigger, latch target_i into tgt_q.
  - If target_i[1:0] != 0, go to EXC.
  - Else, if cnt_next == 0, go to REDIRECT.
  - Else, go to DRAIN.
- DRAIN: when cnt_next == 0, go to REDIRECT.
- REDIRECT: go to IDLE unconditionally.
- EXC: go to IDLE unconditionally. No redirect is issued; the trap unit owns recovery.
- Outputs (combinational from state and inputs):
  - flush_if_o = flush_id_o = trigger | (state != IDLE).
  - fetch_hold_o = trigger | (state ∈ {DRAIN, REDIRECT, EXC}) | (cnt == MAX_OUTSTANDING).
  - drop_rsp_o = imem_rsp_valid_i & (trigger | state == DRAIN).
  - redirect_valid_o = (state == REDIRECT); redirect_pc_o = tgt_q.
  - exc_misaligned_o = (state == EXC).
  - busy_o = (state != IDLE).
- Requests accepted in the trigger cycle are counted and their responses dropped.

## Timing
- Reset (rst_ni low at a rising edge):
  - state = IDLE, cnt = 0, tgt_q = 0.
  - Registered-derived outputs are 0: redirect_valid_o, redirect_pc_o, exc_misaligned_o, busy_o.
  - flush_if_o, flush_id_o, fetch_hold_o and drop_rsp_o are 0 while the trigger and imem inputs are low.
- Reset mid-DRAIN or mid-REDIRECT aborts the sequence. No redirect pulse follows.
- Trigger at cycle T:
  - Flush and hold asserted in T itself (same-cycle kill of IF/ID).
  - With no outstanding fetch: redirect_valid_o high in T+1 only; fetch released in T+2.
  - With k responses outstanding, last returning in cycle R ≥ T: redirect_valid_o in R+1.
- exc_misaligned_o: high in T+1 only.
- redirect_valid_o and exc_misaligned_o never assert together and never assert for two consecutive cycles.
- Minimum spacing between two sequences: trigger T, REDIRECT T+1, next trigger accepted T+2.

## Test plan
- Reset then idle, no traffic → every output 0; busy_o 0 for 10 cycles.
- cnt=0, trigger with target 0x0000_0100 at T → flush/hold in T; redirect_valid_o=1 with redirect_pc_o=0x100 at T+1 only; busy_o 0 at T+2.
- Two requests accepted before T, responses at T+2 and T+4, trigger target 0x2000 → drop_rsp_o high at T+2 and T+4; redirect at T+5 with pc 0x2000; fetch_hold_o high T..T+5.
- Trigger with target 0x0000_0102 → exc_misaligned_o at T+1; redirect_valid_o never asserted; state IDLE at T+2.
- Simultaneous accept+rsp at cnt=1 during DRAIN → cnt stays 1, no redirect; later lone rsp → redirect next cycle. Accept at cnt==MAX_OUTSTANDING → cnt unchanged, fetch_hold_o high.
- rst_ni low for one cycle during DRAIN → next cycle IDLE, cnt 0, no redirect pulse. Second trigger while busy → ignored; tgt_q unchanged.

Source files
------------

// File: rtl/branch_redirect_ctrl.sv
// Fetch redirect sequencer for taken branches/jumps resolved in EX: kills IF/ID,
// holds fetch while wrong-path imem responses drain, then pulses the new PC.
module branch_redirect_ctrl #(
  parameter int unsigned XLEN            = 32,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            ex_valid_i,
  input  logic            take_branch_i,
  input  logic [XLEN-1:0] target_i,
  input  logic            imem_req_accept_i,
  input  logic            imem_rsp_valid_i,
  output logic            flush_if_o,
  output logic            flush_id_o,
  output logic            fetch_hold_o,
  output logic            drop_rsp_o,
  output logic            redirect_valid_o,
  output logic [XLEN-1:0] redirect_pc_o,
  output logic            exc_misaligned_o,
  output logic            busy_o
);

  localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {IDLE, DRAIN, REDIRECT, EXC} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_next;
  logic [XLEN-1:0] tgt_q;
  logic            trigger;
  logic            inc, dec;

  assign trigger = ex_valid_i & take_branch_i & (state_q == IDLE);

  // Stray responses at zero and accepts beyond the limit are ignored.
  always_comb begin
    inc      = imem_req_accept_i & (cnt_q != CNT_MAX);
    dec      = imem_rsp_valid_i & (cnt_q != '0);
    cnt_next = cnt_q;
    if (inc && !dec)
      cnt_next = cnt_q + 1'b1;
    else if (dec && !inc)
      cnt_next = cnt_q - 1'b1;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (trigger) begin
          if (target_i[1:0] != 2'b00)
            state_d = EXC;
          else if (cnt_next == '0)
            state_d = REDIRECT;
          else
            state_d = DRAIN;
        end
      end
      DRAIN:    if (cnt_next == '0) state_d = REDIRECT;
      REDIRECT: state_d = IDLE;
      EXC:      state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      tgt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_next;
      if (trigger)
        tgt_q <= target_i;
    end
  end

  assign flush_if_o       = trigger | (state_q != IDLE);
  assign flush_id_o       = trigger | (state_q != IDLE);
  assign fetch_hold_o     = trigger | (state_q != IDLE) | (cnt_q == CNT_MAX);
  assign drop_rsp_o       = imem_rsp_valid_i & (trigger | (state_q == DRAIN));
  assign redirect_valid_o = (state_q == REDIRECT);
  assign redirect_pc_o    = tgt_q;
  assign exc_misaligned_o = (state_q == EXC);
  assign busy_o           = (state_q != IDLE);

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Directed bench for branch_redirect_ctrl; expected values are hand-derived per cycle.
module tb_branch_redirect_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid, take_branch, req_accept, rsp_valid;
  logic [31:0] target;
  logic        flush_if, flush_id, fetch_hold, drop_rsp, redirect_valid, exc_misaligned, busy;
  logic [31:0] redirect_pc;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  always #5 clk = ~clk;

  branch_redirect_ctrl #(.XLEN(32), .MAX_OUTSTANDING(2)) dut (
    .clk_i             (clk),
    .rst_ni            (rst_n),
    .ex_valid_i        (ex_valid),
    .take_branch_i     (take_branch),
    .target_i          (target),
    .imem_req_accept_i (req_accept),
    .imem_rsp_valid_i  (rsp_valid),
    .flush_if_o        (flush_if),
    .flush_id_o        (flush_id),
    .fetch_hold_o      (fetch_hold),
    .drop_rsp_o        (drop_rsp),
    .redirect_valid_o  (redirect_valid),
    .redirect_pc_o     (redirect_pc),
    .exc_misaligned_o  (exc_misaligned),
    .busy_o            (busy)
  );

  // Drive this cycle's inputs shortly after the rising edge.
  task automatic drv(input logic ev, input logic tb, input logic [31:0] tg,
                     input logic acc, input logic rsp);
    ex_valid = ev; take_branch = tb; target = tg; req_accept = acc; rsp_valid = rsp;
    #1;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // exp bit order: {flush_if, flush_id, fetch_hold, drop_rsp, redirect_valid, exc_misaligned, busy}
  task automatic chk(input string tag, input logic [6:0] exp, input logic [31:0] exp_pc);
    logic [6:0] obs;
    obs = {flush_if, flush_id, fetch_hold, drop_rsp, redirect_valid, exc_misaligned, busy};
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s outs: observed %b expected %b", tag, obs, exp);
    end
    n_cmp++;
    assert (redirect_pc === exp_pc) else begin
      n_bad++;
      $error("FAIL %s pc: observed %h expected %h", tag, redirect_pc, exp_pc);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    drv(0, 0, 32'h0, 0, 0);
    cyc(); cyc();
    chk("reset", 7'b0000000, 32'h0);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("idle", 7'b0000000, 32'h0);
    end

    // aligned target, nothing outstanding
    drv(1, 1, 32'h0000_0100, 0, 0);
    chk("t2_T", 7'b1110000, 32'h0);
    cyc(); drv(0, 0, 32'h0, 0, 0);
    chk("t2_T1", 7'b1110101, 32'h100);
    cyc();
    chk("t2_T2", 7'b0000000, 32'h100);

    // two requests outstanding, responses at T+2 and T+4
    drv(0, 0, 32'h0, 1, 0);
    chk("t3_acc1", 7'b0000000, 32'h100);
    cyc();
    chk("t3_acc2", 7'b0000000, 32'h100);
    cyc(); drv(1, 1, 32'h0000_2000, 0, 0);
    chk("t3_T", 7'b1110000, 32'h100);
    cyc(); drv(0, 0, 32'h0, 0, 0);
    chk("t3_T1", 7'b1110001, 32'h2000);
    cyc(); drv(0, 0, 32'h0, 0, 1);
    chk("t3_T2", 7'b1111001, 32'h2000);
    cyc(); drv(0, 0, 32'h0, 0, 0);
    chk("t3_T3", 7'b1110001, 32'h2000);
    cyc(); drv(0, 0, 32'h0, 0, 1);
    chk("t3_T4", 7'b1111001, 32'h2000);
    cyc(); drv(0, 0, 32'h0, 0, 0);
    chk("t3_T5", 7'b1110101, 32'h2000);
    cyc();
    chk("t3_T6", 7'b0000000, 32'h2000);

    // misaligned target
    drv(1, 1, 32'h0000_0102, 0, 0);
    chk("t4_T", 7'b1110000, 32'h2000);
    cyc(); drv(0, 0, 32'h0, 0, 0);
    chk("t4_T1", 7'b1110011, 32'h102);
    cyc();
    chk("t4_T2", 7'b0000000, 32'h102);

    // accept+rsp together during DRAIN, then a second trigger while busy
    drv(0, 0, 32'h0, 1, 0);
    cyc(); drv(1, 1, 32'h0000_0300, 0, 0);
    chk("t5_T", 7'b1110000, 32'h102);
    cyc(); drv(0, 0, 32'h0, 1, 1);
    chk("t5_both", 7'b1111001, 32'h300);
    cyc(); drv(1, 1, 32'h0000_0400, 0, 0);
    chk("t5_busytrig", 7'b1110001, 32'h300);
    cyc(); drv(0, 0, 32'h0, 0, 1);
    chk("t5_lone_rsp", 7'b1111001, 32'h300);
    cyc(); drv(0, 0, 32'h0, 0, 0);
    chk("t5_redir", 7'b1110101, 32'h300);
    cyc();
    chk("t5_idle", 7'b0000000, 32'h300);

    // counter saturation at MAX_OUTSTANDING
    drv(0, 0, 32'h0, 1, 0);
    cyc();
    cyc(); drv(0, 0, 32'h0, 0, 0);
    chk("sat_full", 7'b0010000, 32'h300);
    drv(0, 0, 32'h0, 1, 0);
    cyc(); drv(0, 0, 32'h0, 0, 0);
    chk("sat_hold", 7'b0010000, 32'h300);
    drv(0, 0, 32'h0, 0, 1);
    cyc(); drv(0, 0, 32'h0, 0, 0);
    chk("sat_one", 7'b0000000, 32'h300);
    drv(0, 0, 32'h0, 0, 1);
    cyc(); drv(1, 1, 32'h0000_0380, 0, 0);
    chk("sat_trig", 7'b1110000, 32'h300);
    cyc(); drv(0, 0, 32'h0, 0, 0);
    chk("sat_redir", 7'b1110101, 32'h380);
    cyc();

    // reset in the middle of DRAIN
    drv(0, 0, 32'h0, 1, 0);
    cyc(); drv(1, 1, 32'h0000_0500, 0, 0);
    chk("t6_T", 7'b1110000, 32'h380);
    cyc(); drv(0, 0, 32'h0, 0, 0);
    rst_n = 1'b0;
    chk("t6_drain", 7'b1110001, 32'h500);
    cyc();
    rst_n = 1'b1;
    chk("t6_after_rst", 7'b0000000, 32'h0);
    cyc();
    chk("t6_no_redir", 7'b0000000, 32'h0);
    drv(1, 1, 32'h0000_0600, 0, 0);
    chk("t6_T2", 7'b1110000, 32'h0);
    cyc(); drv(0, 0, 32'h0, 0, 0);
    chk("t6_cnt0", 7'b1110101, 32'h600);
    cyc();
    chk("t6_end", 7'b0000000, 32'h600);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
